clk_reset_sequencer: RTL and testbench
======================================

// Module: clk_reset_sequencer
// PURPOSE
//  Sequences system bring-up behind the Gowin rPLL. Waits for PLL lock, lets the clock settle,
//  holds a timed system reset, then issues the Z8 core clock-enable strobe. Also handles lock
//  loss, the debounced user reset button and STOP/wake handshaking. Runs on the PLL output clock.
// PARAMETERS
//  SETTLE_CYCLES   1024  cycles held in SETTLE after synchronized lock (>=1)
//  RESET_CYCLES    16    cycles sys_reset is held in RESET_HOLD (>=1)
//  CE_DIV          4     cpu_ce period in clk cycles; 1 = cpu_ce high continuously in RUN (>=1)
//  DEBOUNCE_CYCLES 4096  consecutive synchronized-button-high cycles needed to trigger a reset (>=1)
// PORTS
//  clk        in   1  PLL clkout domain clock; the only clock
//  reset      in   1  synchronous, active-high block reset
//  pll_lock   in   1  rPLL LOCK, asynchronous; 2-FF synchronized internally
//  btn_reset  in   1  raw user reset button, active-high, asynchronous; 2-FF synchronized
//  halt_req   in   1  core STOP request; sampled only in cycles where cpu_ce=1
//  wake       in   1  wake event (interrupt/port edge); sampled only in HALT
//  sys_reset  out  1  synchronous reset to the rest of the design, active-high
//  cpu_ce     out  1  single-cycle core clock-enable strobe
//  ready      out  1  high in RUN and HALT
// BEHAVIOUR
//  - All outputs registered, updated on the same edge as state. Counter widths: $clog2 of max count.
//  - reset=1: state=WAIT_LOCK, sys_reset=1, cpu_ce=0, ready=0, all counters and synchronizers 0.
//  - States: WAIT_LOCK, SETTLE, RESET_HOLD, RUN, HALT. sys_reset=1 except in RUN/HALT.
//  - WAIT_LOCK: on lock_s=1 -> SETTLE, cnt=0.
//  - SETTLE: cnt++ each cycle; when cnt==SETTLE_CYCLES-1 -> RESET_HOLD, cnt=0.
//  - RESET_HOLD: cnt++; when cnt==RESET_CYCLES-1 -> RUN, div=0.
//  - Net latency: first edge sampling pll_lock=1 at edge k -> sys_reset falls and ready rises
//    at edge k+2+SETTLE_CYCLES+RESET_CYCLES.
//  - RUN: div counts 0..CE_DIV-1, wrapping; cpu_ce=1 in the cycle where div==CE_DIV-1.
//    The first strobe therefore occurs in the CE_DIV-th cycle of RUN.
//  - RUN, halt_req=1 while cpu_ce=1 -> HALT. That strobe is still delivered; no further cpu_ce.
//  - HALT: cpu_ce=0, ready=1, sys_reset=0. wake=1 -> RUN with div=0, so the first strobe follows
//    CE_DIV cycles later. halt_req is ignored in HALT.
//  - Lock loss: lock_s=0 in any state other than WAIT_LOCK -> WAIT_LOCK. Next edge gives
//    sys_reset=1, cpu_ce=0, ready=0 and clears cnt/div. Lock glitches during SETTLE restart
//    settling from 0.
//  - Button: deb counter increments while btn_s=1 and clears when btn_s=0. On reaching
//    DEBOUNCE_CYCLES-1 in RUN or HALT -> RESET_HOLD, cnt=0. deb then saturates; no retrigger
//    until btn_s returns to 0. The button is ignored in WAIT_LOCK/SETTLE/RESET_HOLD, but the
//    deb count still runs.
//  - Priority on the same edge: reset > lock loss > button trigger > wake/halt_req.
//  - Wrap: cnt/div never exceed their terminal values; deb saturates.
// TESTING
//  Params SETTLE=8, RESET=4, CE_DIV=3, DEBOUNCE=4 unless noted.
//  1 Bring-up: reset then pll_lock=1 sampled at edge 0 -> sys_reset=1 through edge 13, falls at
//    edge 14. cpu_ce first high in the 3rd RUN cycle, then every 3 cycles.
//  2 Lock glitch: drop pll_lock for 1 cycle at SETTLE cnt=5 -> back to WAIT_LOCK. Full 8-cycle
//    settle repeats; sys_reset timing shifts accordingly.
//  3 Run-time lock loss: pll_lock=0 in RUN -> 3 edges later sys_reset=1, ready=0, cpu_ce=0.
//    Relock repeats the 14-cycle sequence.
//  4 Button: btn_reset high 3 cycles -> no effect. High 10 cycles -> one RESET_HOLD of 4 cycles,
//    and no second trigger while still held.
//  5 Halt/wake: halt_req=1 across a strobe -> that strobe seen, then cpu_ce=0, ready=1.
//    wake=1 -> next strobe exactly 3 cycles later.
//  6 CE_DIV=1 -> cpu_ce=1 every RUN cycle. Simultaneous lock loss and button trigger ->
//    WAIT_LOCK wins. Mid-sequence reset=1 -> WAIT_LOCK with outputs at reset values.

Source files
------------

// File: rtl/clk_reset_sequencer.sv
// clk_reset_sequencer
//   Brings the system up behind the rPLL. It waits for a synchronized PLL lock,
//   lets the clock settle, holds a timed system reset, and then issues the core
//   clock-enable strobe. It also handles lock loss, a debounced user reset button
//   and STOP/wake handshaking. Everything runs on the PLL output clock.
// Ports
//   clk       : PLL output clock (the only clock)
//   reset     : synchronous, active-high block reset
//   pll_lock  : rPLL LOCK, asynchronous, 2-FF synchronized here
//   btn_reset : raw user reset button, active-high, asynchronous, 2-FF synchronized here
//   halt_req  : core STOP request, honoured only in a cycle where cpu_ce=1
//   wake      : wake event, honoured only in HALT
//   sys_reset : registered active-high reset to the rest of the design
//   cpu_ce    : registered single-cycle core clock-enable strobe
//   ready     : registered, high in RUN and HALT
module clk_reset_sequencer #(
  parameter int SETTLE_CYCLES   = 1024,
  parameter int RESET_CYCLES    = 16,
  parameter int CE_DIV          = 4,
  parameter int DEBOUNCE_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic pll_lock,
  input  logic btn_reset,
  input  logic halt_req,
  input  logic wake,
  output logic sys_reset,
  output logic cpu_ce,
  output logic ready
);

  // cnt is shared by SETTLE and RESET_HOLD, so size it for the larger terminal value.
  localparam int CNT_MAX = ((SETTLE_CYCLES > RESET_CYCLES) ? SETTLE_CYCLES : RESET_CYCLES) - 1;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam int DW      = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;
  // deb saturates one step past the trigger value, which makes the trigger one-shot
  // for each press.
  localparam int BW      = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [2:0] S_WAIT_LOCK  = 3'd0;
  localparam logic [2:0] S_SETTLE     = 3'd1;
  localparam logic [2:0] S_RESET_HOLD = 3'd2;
  localparam logic [2:0] S_RUN        = 3'd3;
  localparam logic [2:0] S_HALT       = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] deb_q, deb_d;
  logic          lock_s1_q, lock_s_q;
  logic          btn_s1_q, btn_s_q;
  logic          sys_reset_q, sys_reset_d;
  logic          cpu_ce_q, cpu_ce_d;
  logic          ready_q, ready_d;
  logic          btn_trig;
  logic          running;

  // The debounce counter runs in every state. Only RUN and HALT act on its trigger.
  assign btn_trig = btn_s_q && (deb_q == BW'(DEBOUNCE_CYCLES - 1));
  assign running  = (state_q == S_RUN) || (state_q == S_HALT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    if (!btn_s_q)                            deb_d = '0;
    else if (deb_q == BW'(DEBOUNCE_CYCLES))  deb_d = deb_q;
    else                                     deb_d = deb_q + 1'b1;

    case (state_q)
      S_WAIT_LOCK: begin
        cnt_d = '0;
        div_d = '0;
        if (lock_s_q) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          state_d = S_RESET_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESET_HOLD: begin
        if (cnt_q == CW'(RESET_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
          div_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        // The strobe in this cycle is already on the output. A halt only stops the
        // strobes that follow it.
        if (cpu_ce_q && halt_req) begin
          state_d = S_HALT;
          div_d   = '0;
        end else if (div_q == DW'(CE_DIV - 1)) begin
          div_d = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HALT: begin
        div_d = '0;
        if (wake) state_d = S_RUN;
      end
      default: begin
        state_d = S_WAIT_LOCK;
        cnt_d   = '0;
        div_d   = '0;
      end
    endcase

    // The later overrides win: lock loss beats the button, and the button beats wake or halt.
    if (running && btn_trig) begin
      state_d = S_RESET_HOLD;
      cnt_d   = '0;
      div_d   = '0;
    end
    if ((state_q != S_WAIT_LOCK) && !lock_s_q) begin
      state_d = S_WAIT_LOCK;
      cnt_d   = '0;
      div_d   = '0;
    end

    // The outputs are computed from next state so that they change on the same edge as state.
    ready_d     = (state_d == S_RUN) || (state_d == S_HALT);
    sys_reset_d = !ready_d;
    cpu_ce_d    = (state_d == S_RUN) && (div_d == DW'(CE_DIV - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_WAIT_LOCK;
      cnt_q       <= '0;
      div_q       <= '0;
      deb_q       <= '0;
      lock_s1_q   <= 1'b0;
      lock_s_q    <= 1'b0;
      btn_s1_q    <= 1'b0;
      btn_s_q     <= 1'b0;
      sys_reset_q <= 1'b1;
      cpu_ce_q    <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      deb_q       <= deb_d;
      lock_s1_q   <= pll_lock;
      lock_s_q    <= lock_s1_q;
      btn_s1_q    <= btn_reset;
      btn_s_q     <= btn_s1_q;
      sys_reset_q <= sys_reset_d;
      cpu_ce_q    <= cpu_ce_d;
      ready_q     <= ready_d;
    end
  end

  assign sys_reset = sys_reset_q;
  assign cpu_ce    = cpu_ce_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_clk_reset_sequencer.sv
module tb_clk_reset_sequencer;

  logic clk;
  logic reset, pll_lock, btn_reset, halt_req, wake;
  logic sys_reset, cpu_ce, ready;
  logic sys_reset1, cpu_ce1, ready1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic lock;
    logic sr;
    logic ce;
    logic rdy;
    logic ce1;
  } vec_t;

  vec_t tv[25];

  clk_reset_sequencer #(
    .SETTLE_CYCLES(8), .RESET_CYCLES(4), .CE_DIV(3), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .pll_lock(pll_lock), .btn_reset(btn_reset),
    .halt_req(halt_req), .wake(wake),
    .sys_reset(sys_reset), .cpu_ce(cpu_ce), .ready(ready)
  );

  clk_reset_sequencer #(
    .SETTLE_CYCLES(8), .RESET_CYCLES(4), .CE_DIV(1), .DEBOUNCE_CYCLES(4)
  ) dut1 (
    .clk(clk), .reset(reset), .pll_lock(pll_lock), .btn_reset(btn_reset),
    .halt_req(halt_req), .wake(wake),
    .sys_reset(sys_reset1), .cpu_ce(cpu_ce1), .ready(ready1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  initial begin
    logic found;
    reset = 1'b1; pll_lock = 1'b0; btn_reset = 1'b0; halt_req = 1'b0; wake = 1'b0;

    // Bring-up table: pll_lock is first sampled at edge 0, so RUN starts at edge 14.
    // The CE_DIV=3 strobe lands in the 3rd RUN cycle. CE_DIV=1 strobes in every RUN cycle.
    for (int e = 0; e < 25; e++) begin
      tv[e].lock = 1'b1;
      tv[e].sr   = (e < 14);
      tv[e].rdy  = (e >= 14);
      tv[e].ce   = (e >= 16) && (((e - 16) % 3) == 0);
      tv[e].ce1  = (e >= 14);
    end

    tick(); tick();
    chk("rst_sys_reset", sys_reset, 1'b1);
    chk("rst_cpu_ce", cpu_ce, 1'b0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_ce1", cpu_ce1, 1'b0);

    reset = 1'b0;
    for (int e = 0; e < 25; e++) begin
      pll_lock = tv[e].lock;
      tick();
      chk($sformatf("bring_sr[%0d]", e), sys_reset, tv[e].sr);
      chk($sformatf("bring_rdy[%0d]", e), ready, tv[e].rdy);
      chk($sformatf("bring_ce[%0d]", e), cpu_ce, tv[e].ce);
      chk($sformatf("bring_ce1[%0d]", e), cpu_ce1, tv[e].ce1);
    end

    // Run-time lock loss: the outputs drop on the third edge after pll_lock falls.
    pll_lock = 1'b0;
    tick(); chk("loss_rdy_e1", ready, 1'b1);
    tick(); chk("loss_rdy_e2", ready, 1'b1);
    chk("loss_ce1_e2", cpu_ce1, 1'b1);
    tick();
    chk("loss_rdy_e3", ready, 1'b0);
    chk("loss_sr_e3", sys_reset, 1'b1);
    chk("loss_ce_e3", cpu_ce, 1'b0);
    chk("loss_ce1_e3", cpu_ce1, 1'b0);
    pll_lock = 1'b1;
    for (int e = 0; e < 15; e++) begin
      tick();
      chk($sformatf("relock_sr[%0d]", e), sys_reset, (e < 14));
    end

    // A short button press (3 cycles) is ignored.
    for (int c = 0; c < 9; c++) begin
      btn_reset = (c < 3);
      tick();
      chk($sformatf("btn_short_rdy[%0d]", c), ready, 1'b1);
    end
    // A long press (10 cycles) gives exactly one 4-cycle RESET_HOLD and no retrigger.
    for (int c = 0; c < 16; c++) begin
      btn_reset = (c < 10);
      tick();
      chk($sformatf("btn_long_sr[%0d]", c), sys_reset, (c >= 5) && (c <= 8));
    end

    // Halt across a strobe, then wake.
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cpu_ce) begin found = 1'b1; break; end
    end
    chk("halt_strobe_seen", found, 1'b1);
    halt_req = 1'b1;
    tick();
    chk("halt_ce", cpu_ce, 1'b0);
    chk("halt_rdy", ready, 1'b1);
    chk("halt_sr", sys_reset, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("halt_hold_ce[%0d]", i), cpu_ce, 1'b0);
      chk($sformatf("halt_hold_rdy[%0d]", i), ready, 1'b1);
    end
    halt_req = 1'b0; wake = 1'b1;
    tick(); chk("wake_ce_c1", cpu_ce, 1'b0);
    wake = 1'b0;
    tick(); chk("wake_ce_c2", cpu_ce, 1'b0);
    tick(); chk("wake_ce_c3", cpu_ce, 1'b1);
    tick(); chk("wake_ce_c4", cpu_ce, 1'b0);

    // A lock glitch and a button trigger on the same edge: lock loss wins, so a
    // full settle follows (release at c18 rather than c9).
    for (int c = 0; c < 21; c++) begin
      btn_reset = (c <= 19);
      pll_lock  = (c != 3);
      tick();
      chk($sformatf("prio_sr[%0d]", c), sys_reset, (c >= 5) && (c < 18));
    end
    btn_reset = 1'b0;

    // A lock glitch during SETTLE restarts settling, so release moves from edge 14 to edge 21.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 0; e < 22; e++) begin
      pll_lock = (e != 6);
      tick();
      chk($sformatf("glitch_sr[%0d]", e), sys_reset, (e < 21));
      chk($sformatf("glitch_rdy[%0d]", e), ready, (e >= 21));
    end

    // A reset in RUN returns the outputs to reset values and clears the synchronizers.
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("midrst_sr", sys_reset, 1'b1);
    chk("midrst_ce", cpu_ce, 1'b0);
    chk("midrst_rdy", ready, 1'b0);
    reset = 1'b0;
    for (int e = 0; e < 15; e++) begin
      tick();
      chk($sformatf("midrst_seq_sr[%0d]", e), sys_reset, (e < 14));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
